// File: rtl/writeback_stage_if.sv
// MEM->WB bundle plus register-file write port and forwarding history.
// Master drives the MEM-stage side, slave is the writeback stage.
interface writeback_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              MEM_Valid;
    logic              MEM_REG_W_En;
    logic [ADDR_W-1:0] MEM_REG_W_Addr;
    logic [1:0]        MEM_Result_Src;
    logic [XLEN-1:0]   MEM_ALU_Result;
    logic [XLEN-1:0]   MEM_PC_Plus_4;
    logic [2:0]        MEM_Funct3;
    logic [XLEN-1:0]   MEM_Read_Data;

    logic              REG_W_En;
    logic [ADDR_W-1:0] REG_W_Addr;
    logic [XLEN-1:0]   REG_W_Data;
    logic              WBH_Valid;
    logic [ADDR_W-1:0] WBH_Addr;
    logic [XLEN-1:0]   WBH_Data;

    modport master (
        output MEM_Valid, MEM_REG_W_En, MEM_REG_W_Addr,
        output MEM_Result_Src, MEM_ALU_Result, MEM_PC_Plus_4,
        output MEM_Funct3, MEM_Read_Data,
        input  REG_W_En, REG_W_Addr, REG_W_Data,
        input  WBH_Valid, WBH_Addr, WBH_Data
    );

    modport slave (
        input  MEM_Valid, MEM_REG_W_En, MEM_REG_W_Addr,
        input  MEM_Result_Src, MEM_ALU_Result, MEM_PC_Plus_4,
        input  MEM_Funct3, MEM_Read_Data,
        output REG_W_En, REG_W_Addr, REG_W_Data,
        output WBH_Valid, WBH_Addr, WBH_Data
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB register, load align/extend, writeback mux and one-deep write history.
// Optional macro RETIRE_COUNTER_EN adds the 64-bit RETIRE_Count output.
module writeback_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic STALL,
    input  logic FLUSH,
    writeback_stage_if.slave bus
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [63:0] RETIRE_Count
`endif
);
    logic              wb_valid;
    logic              wb_w_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [1:0]        wb_src;
    logic [XLEN-1:0]   wb_alu;
    logic [XLEN-1:0]   wb_pc4;
    logic [2:0]        wb_f3;
    logic [XLEN-1:0]   wb_rd;

    logic              wbh_valid;
    logic [ADDR_W-1:0] wbh_addr;
    logic [XLEN-1:0]   wbh_data;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   w_data;
    logic              w_en;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_valid <= 1'b0;
            wb_w_en  <= 1'b0;
            wb_addr  <= '0;
            wb_src   <= '0;
            wb_alu   <= '0;
            wb_pc4   <= '0;
            wb_f3    <= '0;
            wb_rd    <= '0;
        end else if (FLUSH) begin
            wb_valid <= 1'b0;
        end else if (!STALL) begin
            wb_valid <= bus.MEM_Valid;
            wb_w_en  <= bus.MEM_REG_W_En;
            wb_addr  <= bus.MEM_REG_W_Addr;
            wb_src   <= bus.MEM_Result_Src;
            wb_alu   <= bus.MEM_ALU_Result;
            wb_pc4   <= bus.MEM_PC_Plus_4;
            wb_f3    <= bus.MEM_Funct3;
            wb_rd    <= bus.MEM_Read_Data;
        end
    end

    // Misaligned halves are not trapped here: off[0] is simply ignored.
    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_data = wb_rd;
        unique case (wb_alu[1:0])
            2'd0:    ld_byte = wb_rd[7:0];
            2'd1:    ld_byte = wb_rd[15:8];
            2'd2:    ld_byte = wb_rd[23:16];
            default: ld_byte = wb_rd[31:24];
        endcase
        ld_half = wb_alu[1] ? wb_rd[31:16] : wb_rd[15:0];
        unique case (wb_f3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = wb_rd;
        endcase
    end

    always_comb begin
        w_data = '0;
        unique case (wb_src)
            2'b00:   w_data = wb_alu;
            2'b01:   w_data = ld_data;
            2'b10:   w_data = wb_pc4;
            default: w_data = '0;
        endcase
    end

    assign w_en = wb_valid & wb_w_en & (wb_addr != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbh_valid <= 1'b0;
            wbh_addr  <= '0;
            wbh_data  <= '0;
        end else if (FLUSH) begin
            wbh_valid <= 1'b0;
        end else if (!STALL) begin
            wbh_valid <= w_en;
            wbh_addr  <= wb_addr;
            wbh_data  <= w_data;
        end
    end

    assign bus.REG_W_En   = w_en;
    assign bus.REG_W_Addr = wb_addr;
    assign bus.REG_W_Data = w_data;
    assign bus.WBH_Valid  = wbh_valid;
    assign bus.WBH_Addr   = wbh_addr;
    assign bus.WBH_Data   = wbh_data;

`ifdef RETIRE_COUNTER_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            RETIRE_Count <= 64'd0;
        else if (wb_valid && !STALL && !FLUSH)
            RETIRE_Count <= RETIRE_Count + 64'd1;
    end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus reset/stall/flush
// sequences; counter checks only when RETIRE_COUNTER_EN is defined.
module tb_writeback_stage;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic STALL = 1'b0;
    logic FLUSH = 1'b0;
`ifdef RETIRE_COUNTER_EN
    logic [63:0] RETIRE_Count;
`endif

    int errors = 0;
    int checks = 0;

    writeback_stage_if #(.XLEN(32), .ADDR_W(5)) bus ();

    writeback_stage #(.XLEN(32), .ADDR_W(5)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .STALL(STALL),
        .FLUSH(FLUSH),
        .bus  (bus)
`ifdef RETIRE_COUNTER_EN
        ,
        .RETIRE_Count(RETIRE_Count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic        wen;
        logic [4:0]  addr;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [31:0] rd;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a,
                         input logic [1:0] s, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [2:0] f3,
                         input logic [31:0] rd);
        bus.MEM_Valid      = v;
        bus.MEM_REG_W_En   = we;
        bus.MEM_REG_W_Addr = a;
        bus.MEM_Result_Src = s;
        bus.MEM_ALU_Result = alu;
        bus.MEM_PC_Plus_4  = pc4;
        bus.MEM_Funct3     = f3;
        bus.MEM_Read_Data  = rd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic        p_en;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        vec[0]  = '{1, 1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'b010, RD,
                    1, 5'd5, 32'h1234_5678};
        vec[1]  = '{1, 1, 5'd6, 2'b01, 32'h0000_1003, 32'h0, 3'b000, RD,
                    1, 5'd6, 32'hFFFF_FF80};
        vec[2]  = '{1, 1, 5'd7, 2'b01, 32'h0000_0002, 32'h0, 3'b100, RD,
                    1, 5'd7, 32'h0000_00FF};
        vec[3]  = '{1, 1, 5'd8, 2'b01, 32'h0000_0002, 32'h0, 3'b001, RD,
                    1, 5'd8, 32'hFFFF_80FF};
        vec[4]  = '{1, 1, 5'd9, 2'b01, 32'h0000_0000, 32'h0, 3'b101, RD,
                    1, 5'd9, 32'h0000_7F01};
        vec[5]  = '{1, 1, 5'd10, 2'b01, 32'h0000_0001, 32'h0, 3'b010, RD,
                    1, 5'd10, 32'h80FF_7F01};
        vec[6]  = '{1, 1, 5'd11, 2'b01, 32'h0000_0003, 32'h0, 3'b011, RD,
                    1, 5'd11, 32'h80FF_7F01};
        vec[7]  = '{1, 1, 5'd0, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b010, RD,
                    0, 5'd0, 32'hDEAD_BEEF};
        vec[8]  = '{1, 1, 5'd1, 2'b10, 32'h0000_0055, 32'h0000_0104, 3'b010, RD,
                    1, 5'd1, 32'h0000_0104};
        vec[9]  = '{1, 1, 5'd2, 2'b11, 32'h0000_0077, 32'h0000_0200, 3'b010, RD,
                    1, 5'd2, 32'h0000_0000};
        vec[10] = '{0, 1, 5'd3, 2'b00, 32'hAAAA_5555, 32'h0, 3'b010, RD,
                    0, 5'd3, 32'hAAAA_5555};
        vec[11] = '{1, 0, 5'd4, 2'b00, 32'h0000_0042, 32'h0, 3'b010, RD,
                    0, 5'd4, 32'h0000_0042};
        vec[12] = '{1, 1, 5'd12, 2'b01, 32'h0000_0003, 32'h0, 3'b001, RD,
                    1, 5'd12, 32'hFFFF_80FF};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_en", {63'd0, bus.REG_W_En}, 64'd0);
        chk("rst_addr", {59'd0, bus.REG_W_Addr}, 64'd0);
        chk("rst_data", {32'd0, bus.REG_W_Data}, 64'd0);
        chk("rst_wbh_v", {63'd0, bus.WBH_Valid}, 64'd0);
        chk("rst_wbh_d", {32'd0, bus.WBH_Data}, 64'd0);
`ifdef RETIRE_COUNTER_EN
        chk("rst_cnt", RETIRE_Count, 64'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;

        // Fill WB and history, then reset mid-cycle.
        drive(1, 1, 5'd9, 2'b00, 32'h0000_0099, 0, 3'b010, 0);
        tick();
        chk("pre_rst_en", {63'd0, bus.REG_W_En}, 64'd1);
        tick();
        chk("pre_rst_wbh", {63'd0, bus.WBH_Valid}, 64'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_en", {63'd0, bus.REG_W_En}, 64'd0);
        chk("mid_rst_wbh", {63'd0, bus.WBH_Valid}, 64'd0);
`ifdef RETIRE_COUNTER_EN
        chk("mid_rst_cnt", RETIRE_Count, 64'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_en", {63'd0, bus.REG_W_En}, 64'd0);

        p_en = 1'b0;
        p_addr = '0;
        p_data = '0;
        for (int i = 0; i < 13; i++) begin
            drive(vec[i].valid, vec[i].wen, vec[i].addr, vec[i].src,
                  vec[i].alu, vec[i].pc4, vec[i].f3, vec[i].rd);
            tick();
            chk($sformatf("v%0d_en", i), {63'd0, bus.REG_W_En},
                {63'd0, vec[i].e_en});
            chk($sformatf("v%0d_addr", i), {59'd0, bus.REG_W_Addr},
                {59'd0, vec[i].e_addr});
            chk($sformatf("v%0d_data", i), {32'd0, bus.REG_W_Data},
                {32'd0, vec[i].e_data});
            chk($sformatf("v%0d_wbh_v", i), {63'd0, bus.WBH_Valid},
                {63'd0, p_en});
            chk($sformatf("v%0d_wbh_a", i), {59'd0, bus.WBH_Addr},
                {59'd0, p_addr});
            chk($sformatf("v%0d_wbh_d", i), {32'd0, bus.WBH_Data},
                {32'd0, p_data});
            p_en = vec[i].e_en;
            p_addr = vec[i].e_addr;
            p_data = vec[i].e_data;
        end

        // A in history, B in WB, then stall with new inputs.
        drive(1, 1, 5'd20, 2'b00, 32'hAAAA_0001, 0, 3'b010, 0);
        tick();
        drive(1, 1, 5'd21, 2'b00, 32'hBBBB_0002, 0, 3'b010, 0);
        tick();
        STALL = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 5'd22 + 5'(c), 2'b00, 32'hCCCC_0000 + c, 0, 3'b010, 0);
            tick();
            chk($sformatf("stall%0d_en", c), {63'd0, bus.REG_W_En}, 64'd1);
            chk($sformatf("stall%0d_addr", c), {59'd0, bus.REG_W_Addr}, 64'd21);
            chk($sformatf("stall%0d_data", c), {32'd0, bus.REG_W_Data},
                64'hBBBB_0002);
            chk($sformatf("stall%0d_wbh_a", c), {59'd0, bus.WBH_Addr}, 64'd20);
            chk($sformatf("stall%0d_wbh_d", c), {32'd0, bus.WBH_Data},
                64'hAAAA_0001);
        end
        FLUSH = 1'b1;
        tick();
        chk("sf_en", {63'd0, bus.REG_W_En}, 64'd0);
        chk("sf_wbh_v", {63'd0, bus.WBH_Valid}, 64'd0);
        STALL = 1'b0;
        FLUSH = 1'b0;

`ifdef RETIRE_COUNTER_EN
        @(negedge CLK);
        RST = 1'b1;
        #1;
        RST = 1'b0;
        // v v S S v v bubble flush v*6 drain: ten valid instructions retire.
        for (int c = 0; c < 15; c++) begin
            logic v, s, f;
            v = !(c == 6 || c == 7 || c == 14);
            s = (c == 2 || c == 3);
            f = (c == 7);
            STALL = s;
            FLUSH = f;
            drive(v, 1, 5'd3, 2'b00, 32'(c), 0, 3'b010, 0);
            tick();
        end
        STALL = 1'b0;
        FLUSH = 1'b0;
        chk("retire_cnt", RETIRE_Count, 64'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus the write-port driver for the register file.
- Captures the memory-stage result each cycle, aligns and extends load data, and selects the writeback source (ALU, load or PC+4).
- Drives REG_W_En / REG_W_Addr / REG_W_Data into the register file.
- Keeps a one-deep history of the last retired write so decode can forward past the synchronous register-file write.

Parameters:
- XLEN, 32, datapath width.
- ADDR_W, 5, register address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- STALL  in  1  hold the WB register contents.
- FLUSH  in  1  load a bubble into the WB register; priority over STALL.
- MEM_Valid  in  1  the MEM-stage instruction is valid.
- MEM_REG_W_En  in  1  the instruction writes rd.
- MEM_REG_W_Addr  in  ADDR_W  rd.
- MEM_Result_Src  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- MEM_ALU_Result  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- MEM_PC_Plus_4  in  XLEN  link value.
- MEM_Funct3  in  3  load type.
- MEM_Read_Data  in  XLEN  raw aligned word from data memory.
- REG_W_En  out  1  register-file write enable.
- REG_W_Addr  out  ADDR_W  register-file write address.
- REG_W_Data  out  XLEN  register-file write data.
- WBH_Valid  out  1  history entry is valid.
- WBH_Addr  out  ADDR_W  history entry rd.
- WBH_Data  out  XLEN  history entry data.
- RETIRE_Count  out  64  retired instruction count; present only with the optional feature.

Behaviour:
- Reset (async on RST rise) clears all WB register and history fields. Every output reads 0 while RST is high and until the first capture.
- Capture on the CLK rising edge:
  - FLUSH=1: wb_valid <= 0; other fields don't-care.
  - else STALL=0: all MEM_* inputs are latched into wb_*.
  - else (STALL=1): hold.
- Latency: one cycle from MEM inputs to REG_W_* outputs; the REG_W_* outputs are combinational from the wb_* registers.
- REG_W_En = wb_valid & wb_w_en & (wb_addr != 0). x0 is never written; REG_W_Addr/REG_W_Data still reflect wb_*.
- Load extraction uses off = wb_alu[1:0]:
  - 000 LB: byte[off], sign-extended.
  - 100 LBU: byte[off], zero-extended.
  - 001 LH: half[off[1]], sign-extended.
  - 101 LHU: half[off[1]], zero-extended.
  - 010 LW: full word, offset ignored.
  - 011/110/111: raw word passed unchanged.
  - Misalignment is not trapped here; off[0] is ignored for halves.
- REG_W_Data by source: 00 wb_alu; 01 extracted load; 10 wb_pc4; 11 zero.
- History register updates on each rising edge with STALL=0 and FLUSH=0:
  - WBH_Valid <= REG_W_En, WBH_Addr <= REG_W_Addr, WBH_Data <= REG_W_Data.
  - FLUSH=1: WBH_Valid <= 0.
  - STALL=1: hold.
- While stalled, REG_W_En stays asserted; the repeated identical write is permitted.
- Reset mid-stall or mid-flush: reset wins and takes effect immediately.

Optional Feature:
- Macro: RETIRE_COUNTER_EN.
- Defined:
  - RETIRE_Count is a 64-bit counter, reset to 0.
  - Increments by 1 on each rising edge where wb_valid=1, STALL=0 and FLUSH=0, i.e. the instruction leaves WB.
  - Bubbles and x0-target instructions still count if valid; the counter wraps at 2^64.
- Undefined: the port is absent and no counter logic is built.

Test Plan:
- Reset: assert RST mid-cycle -> REG_W_En=0, WBH_Valid=0 and RETIRE_Count=0 immediately; no write seen on the next edge.
- ALU writeback: Valid=1, W_En=1, Addr=5, Src=00, ALU=0x1234_5678 -> next cycle REG_W_En=1, Addr=5, Data=0x1234_5678; following cycle WBH_Valid=1, WBH_Addr=5, WBH_Data=0x1234_5678.
- Loads with Read_Data=0x80FF_7F01, Src=01:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=2 -> 0x0000_00FF.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
- x0 and link: Addr=0, Src=00, ALU=0xDEAD_BEEF -> REG_W_En=0. Addr=1, Src=10, PC4=0x0000_0104 -> Data=0x0000_0104.
- Stall/flush:
  - STALL for 3 cycles with new MEM inputs -> outputs and history hold the old values.
  - Simultaneous STALL=1 and FLUSH=1 -> REG_W_En=0 and WBH_Valid=0 after the edge.
- Counter (RETIRE_COUNTER_EN): 10 valid instructions with 2 stall cycles and 1 flush bubble -> RETIRE_Count=10.
